// File: rtl/fft_to_ram_pkg.sv
// Shared layout definitions for the waterfall RAM, used by both the FFT write path and the display read path.
// Both sides must agree on how a frame slot maps to a bank and a base address.
package fft_to_ram_pkg;

  localparam int NO_BANKS       = 2;
  localparam int RAM_ADDR_WIDTH = 12;
  localparam int RAM_DATA_WIDTH = 4;
  localparam int IN_WIDTH       = 16;
  localparam int MAG_SHIFT      = 8;
  localparam int NO_FFTS        = 50;
  localparam int FFT_SIZE       = 256;

  localparam int FFT_IDX_WIDTH  = $clog2(NO_FFTS);
  localparam int BIN_WIDTH      = $clog2(FFT_SIZE / 2);
  localparam int CNT_WIDTH      = $clog2(FFT_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP,
    ST_COMMIT
  } state_t;

  // The slot MSB picks the bank, so slots 0..31 go to bank 0 and 32..49 go to bank 1.
  function automatic logic [NO_BANKS-1:0] bank_select(input logic [FFT_IDX_WIDTH-1:0] slot);
    bank_select = '0;
    for (int b = 0; b < NO_BANKS; b++) begin
      if (int'(slot >> (FFT_IDX_WIDTH - 1)) == b) bank_select[b] = 1'b1;
    end
  endfunction

  // The remaining slot bits select a 128-entry row block inside the bank.
  function automatic logic [RAM_ADDR_WIDTH-1:0] slot_base(input logic [FFT_IDX_WIDTH-1:0] slot);
    slot_base = RAM_ADDR_WIDTH'(slot) << BIN_WIDTH;
  endfunction

endpackage

// File: rtl/fft_to_ram_mag_quantise.sv
// Combinational magnitude quantiser: drop the low bits, then saturate to the stored width.
module mag_quantise #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4,
  parameter int SHIFT     = 8
) (
  input  logic [IN_WIDTH-1:0]  mag,
  output logic [OUT_WIDTH-1:0] q
);

  logic [IN_WIDTH-1:0] shifted;

  assign shifted = mag >> SHIFT;
  assign q = (shifted > IN_WIDTH'((1 << OUT_WIDTH) - 1)) ? '1 : shifted[OUT_WIDTH-1:0];

endmodule

// File: rtl/fft_to_ram.sv
// Streams FFT magnitude frames into the banked waterfall RAM and owns the circular frame pointer.
// Only bins 0..FFT_SIZE/2-1 are stored; a frame is committed only when s_last lands on the final bin.
module fft_to_ram
  import fft_to_ram_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic [NO_BANKS-1:0]       wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0] wr_address,
  output logic [RAM_DATA_WIDTH-1:0] wr_data,
  output logic [FFT_IDX_WIDTH-1:0]  oldest_fft_idx,
  output logic                      frame_done,
  output logic                      frame_err
);

  state_t                    state;
  logic [CNT_WIDTH-1:0]      bin_cnt;
  logic [FFT_IDX_WIDTH-1:0]  wr_idx;
  logic [RAM_DATA_WIDTH-1:0] q;
  logic                      accept;
  logic                      lower_half;
  logic                      last_bin;
  logic                      storing;

  mag_quantise #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(RAM_DATA_WIDTH),
    .SHIFT    (MAG_SHIFT)
  ) u_quant (
    .mag(s_data),
    .q  (q)
  );

  assign s_ready        = (state != ST_COMMIT);
  assign accept         = s_valid & s_ready;
  assign lower_half     = (bin_cnt < CNT_WIDTH'(FFT_SIZE / 2));
  assign last_bin       = (bin_cnt == CNT_WIDTH'(FFT_SIZE - 1));
  assign storing        = (state == ST_IDLE) || (state == ST_WRITE);
  // The write slot is always the oldest slot: it is overwritten by the frame in progress.
  assign oldest_fft_idx = wr_idx;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bin_cnt        <= '0;
      wr_idx         <= '0;
      wr_bank_select <= '0;
      wr_address     <= '0;
      wr_data        <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      wr_bank_select <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;

      if (accept && storing && lower_half) begin
        wr_bank_select <= bank_select(wr_idx);
        wr_address     <= slot_base(wr_idx) | RAM_ADDR_WIDTH'(bin_cnt[BIN_WIDTH-1:0]);
        wr_data        <= q;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (s_last) begin
              frame_err <= 1'b1;
            end else begin
              bin_cnt <= CNT_WIDTH'(1);
              state   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (accept) begin
            if (s_last) begin
              bin_cnt <= '0;
              if (last_bin) begin
                state <= ST_COMMIT;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
              end
            end else if (last_bin) begin
              // Overlong frame: swallow the rest up to its s_last without writing.
              frame_err <= 1'b1;
              bin_cnt   <= '0;
              state     <= ST_DROP;
            end else begin
              bin_cnt <= bin_cnt + CNT_WIDTH'(1);
            end
          end
        end
        ST_DROP: begin
          if (accept && s_last) state <= ST_IDLE;
        end
        ST_COMMIT: begin
          wr_idx     <= (wr_idx == FFT_IDX_WIDTH'(NO_FFTS - 1)) ? '0 : wr_idx + FFT_IDX_WIDTH'(1);
          frame_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_to_ram.sv
// Scoreboard bench for fft_to_ram: stimulus pushes expected writes/frame events, a negedge monitor pops and compares.
module tb_fft_to_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [1:0]  wr_bank_select;
  logic [11:0] wr_address;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        frame_done;
  logic        frame_err;

  fft_to_ram dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .wr_bank_select(wr_bank_select),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .oldest_fft_idx(oldest_fft_idx),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [3:0]  data;
  } wr_t;

  typedef struct {
    logic       done;
    logic       err;
    logic [5:0] idx;
  } ev_t;

  wr_t exp_wr[$];
  ev_t exp_ev[$];

  int checks = 0;
  int errors = 0;
  int ready_lows = 0;
  int commits = 0;
  logic prev_ready = 1'b1;

  // Reference state of the frame pointer and bin position.
  int m_idx = 0;
  int m_bin = 0;
  bit m_drop = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] quant(input logic [15:0] d);
    int v;
    v = int'(d) / 256;
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  task automatic model(input logic [15:0] d, input logic last);
    wr_t w;
    ev_t e;
    if (m_drop) begin
      if (last) m_drop = 0;
      return;
    end
    if (m_bin < 128) begin
      w.bank = (m_idx >= 32) ? 2'b10 : 2'b01;
      w.addr = 12'((m_idx % 32) * 128 + m_bin);
      w.data = quant(d);
      exp_wr.push_back(w);
    end
    if (last && m_bin == 255) begin
      m_idx = (m_idx == 49) ? 0 : m_idx + 1;
      e.done = 1'b1; e.err = 1'b0; e.idx = 6'(m_idx);
      exp_ev.push_back(e);
      m_bin = 0;
      commits++;
    end else if (last || m_bin == 255) begin
      e.done = 1'b0; e.err = 1'b1; e.idx = 6'(m_idx);
      exp_ev.push_back(e);
      m_drop = !last;
      m_bin = 0;
    end else begin
      m_bin++;
    end
  endtask

  function automatic logic [15:0] pattern(input int f, input int i);
    logic [15:0] table_v [8];
    table_v = '{16'h0000, 16'h00FF, 16'h0100, 16'h0EFF, 16'h0F00, 16'h0FFF, 16'h1000, 16'hFFFF};
    if (f == 0) return 16'(i * 256);
    if (f == 1 && i < 8) return table_v[i];
    return 16'((i * 251 + f * 4099) & 16'hFFFF);
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [15:0] d, input logic last, input int gap);
    bit ok;
    logic rdy;
    ok = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
    end
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else model(d, last);
  endtask

  task automatic send_frame(input int n, input int last_at, input int f, input bit gapped);
    for (int i = 0; i < n; i++)
      send_beat(pattern(f, i), (i == last_at), gapped ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic settle_and_check_idx(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(oldest_fft_idx), 32'(m_idx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_oldest"}, 32'(oldest_fft_idx), 32'd0);
    check({tag, "_bank_sel"}, 32'(wr_bank_select), 32'd0);
    check({tag, "_address"}, 32'(wr_address), 32'd0);
    check({tag, "_data"}, 32'(wr_data), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_err"}, 32'(frame_err), 32'd0);
  endtask

  // Monitor: every DUT write or frame event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_bank_select != 2'b00) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {18'd0, wr_bank_select, wr_address}, 32'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write", {14'd0, wr_bank_select, wr_address, wr_data}, {14'd0, w.bank, w.addr, w.data});
        end
      end
      if (frame_done || frame_err) begin
        if (exp_ev.size() == 0) begin
          check("unexpected_event", {24'd0, frame_done, frame_err, oldest_fft_idx}, 32'd0);
        end else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("frame_event", {24'd0, frame_done, frame_err, oldest_fft_idx}, {24'd0, e.done, e.err, e.idx});
        end
      end
      if (!s_ready) begin
        ready_lows++;
        check("ready_low_single_cycle", 32'(prev_ready), 32'd1);
      end
      prev_ready = s_ready;
    end else begin
      prev_ready = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Clean frame with magnitude = bin*256: stored value = min(bin,15), pointer 0 -> 1.
    send_frame(256, 255, 0, 0);
    settle_and_check_idx("idx_after_frame0");
    check("idx_is_one", 32'(oldest_fft_idx), 32'd1);

    // Quantiser boundary values at the start of the frame.
    send_frame(256, 255, 1, 0);
    settle_and_check_idx("idx_after_boundary_frame");

    // Early s_last at bin 100: error, pointer held, next frame rewrites the same slot.
    send_frame(101, 100, 2, 0);
    settle_and_check_idx("idx_after_short_frame");
    send_frame(256, 255, 3, 0);
    settle_and_check_idx("idx_after_rewrite");

    // 300-beat frame: error at bin 255, remainder dropped, then a normal frame.
    send_frame(300, 299, 4, 0);
    settle_and_check_idx("idx_after_long_frame");
    send_frame(256, 255, 5, 0);
    settle_and_check_idx("idx_after_recovery");

    // Random valid gaps must give the same write sequence as a gapless frame.
    send_frame(256, 255, 5, 1);
    settle_and_check_idx("idx_after_gapped");

    // Reset pulse while bin 60 is due: the in-flight write of bin 59 is lost.
    send_frame(60, -1, 6, 0);
    void'(exp_wr.pop_back());
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_idx = 0; m_bin = 0; m_drop = 0;
    @(posedge clk);
    #1;
    send_frame(256, 255, 7, 0);
    settle_and_check_idx("idx_after_reset_frame");

    // 50 frames from slot 1 pass through slot 32 (bank 1), slot 49 (base 2176), wrap to 0, back to 1.
    for (int f = 0; f < 50; f++) begin
      send_frame(256, 255, 8 + f, 0);
      if (m_idx == 0) settle_and_check_idx("idx_wrap_to_zero");
    end
    settle_and_check_idx("idx_after_50_frames");
    check("idx_full_circle", 32'(oldest_fft_idx), 32'd1);

    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_events", 32'(exp_ev.size()), 32'd0);
    check("ready_low_cycles", 32'(ready_lows), 32'(commits));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
